ks_audio_out: RTL and testbench
===============================

# ks_audio_out

Output stage directly downstream of the Karplus-Strong string voice. It accepts the voice's signed 8-bit sample stream and holds one sample per output frame. It applies volume attenuation and a click-free mute ramp, then converts the result to a 1-bit audio pin using either PWM or first-order sigma-delta. It also emits a frame strobe that paces the voice (drives its sample-rate enable) and reports overrun/underrun of the sample handshake.

## Interface
Parameters:
- DATA_WIDTH, 8, sample width; the frame is 2^DATA_WIDTH clocks
- RAMP_STEP, 1, max change of output level per frame (LSBs) during mute/unmute ramps

Ports:
- clk_i  in  1  system clock; one clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sample_i  in  DATA_WIDTH  signed two's-complement sample from the string voice
- sample_valid_i  in  1  one-cycle strobe; sample_i is valid this cycle
- volume_i  in  3  attenuation shift, 0..7 (arithmetic right shift of the sample)
- mute_i  in  1  level 1 = ramp output to silence (midscale)
- mode_i  in  1  0 = PWM, 1 = sigma-delta
- overrun_clr_i  in  1  clears both sticky flags
- audio_o  out  1  registered 1-bit audio
- frame_o  out  1  one-cycle pulse on the last cycle of each frame
- muted_o  out  1  high in MUTED state
- overrun_o  out  1  sticky: a sample was lost
- underrun_o  out  1  sticky: a frame started in PLAY with no new sample

## Operation
- Frame counter cnt, DATA_WIDTH bits, free-running 0..2^W-1, wraps to 0. frame_o = 1 when cnt == 2^W-1.
- Pending buffer, one entry (pend, pend_full):
  - sample_valid_i writes pend and sets pend_full.
  - If pend_full is already set and no transfer occurs that cycle, the new sample overwrites pend and overrun_o is set.
- Transfer occurs on the frame_o cycle:
  - If sample_valid_i is high that same cycle, sample_i goes straight to target and pend_full ends 0. No overrun.
  - Else if pend_full, pend goes to target and pend_full is cleared.
  - Else target is held (repeat last sample). underrun_o is set if the state is PLAY.
- target = sample >>> volume_i, sign-preserving. volume_i is sampled at transfer time.
- level is a signed DATA_WIDTH register, updated on frame_o only. Goal = 0 if mute_i, else target. Level moves toward goal by min(|goal-level|, RAMP_STEP). The difference is computed at DATA_WIDTH+1 bits, so there is no wrap.
- FSM, evaluated on frame_o:
  - MUTED: level==0 and mute_i. Go to RAMP when mute_i drops.
  - RAMP: level != goal. Go to PLAY when level==goal and !mute_i. Go to MUTED when level==0 and mute_i.
  - PLAY: level tracks target. Go to RAMP on mute_i, or when |target-level| > RAMP_STEP.
  - Reset state: MUTED.
- duty = level with MSB inverted (offset binary). Signed 0 gives midscale 2^(W-1).
- PWM mode: audio_o <= (cnt < duty).
- Sigma-delta mode: acc is W+1 bits, acc <= acc[W-1:0] + duty each cycle, and audio_o <= carry (acc[W]).
- mode_i is registered on frame_o. A change takes effect from the next frame. acc is cleared on a mode change.
- overrun_clr_i clears both flags. If a set event coincides with the clear, set wins.

## Timing
- Reset values: cnt=0, level=0, target=0, pend_full=0, acc=0, state MUTED. Outputs: audio_o=0, frame_o=0, muted_o=1, overrun_o=0, underrun_o=0.
- frame_o is combinational from the cnt register, high during cycle 2^W-1.
- A sample transferred at frame_o affects level/duty starting at cnt=0 of the next frame. audio_o reflects that duty one clock later (registered).
- Sample-in to pin latency: at most 2 frames + 1 clock in PLAY.
- Reset assertion mid-frame returns everything to reset values immediately (asynchronous). Release is synchronized by the system reset tree.

## Structure
- The shared package holds the FSM state enum (MUTED, RAMP, PLAY), the mode encoding, and the default DATA_WIDTH/RAMP_STEP constants.
- One natural sub-module, ks_pwm_sd_mod: counter compare + sigma-delta accumulator, taking duty/mode/cnt and producing the registered audio bit. The handshake, buffer, ramp and FSM stay in the top module.

## Test plan
- Reset release, mute_i=1, no samples → muted_o=1, duty 0x80, PWM audio_o high for 128 of every 256 clocks, no flags set.
- mute_i=0, RAMP_STEP=1, one valid 0x10 per frame → level steps 0→16 over 16 frames in RAMP, then PLAY. PWM high count per frame is 144.
- Two sample_valid_i within one frame (0x20 then 0x30) → overrun_o=1, next target 0x30. overrun_clr_i → flag cleared.
- sample_valid_i (0x7F) coincident with frame_o, volume_i=2 → target 0x1F next frame, no overrun, pend_full stays 0.
- In PLAY, omit a sample for one frame → underrun_o=1, level unchanged. Sigma-delta mode, level 0x40 (duty 0xC0) → exactly 192 ones per 256 clocks after the first frame.
- Assert rst_n low mid-frame at cnt=100 → all outputs at reset values the same cycle. After release, cnt restarts at 0.

Source files
------------

// File: rtl/ks_audio_out_pkg.sv
// Shared types and defaults for the Karplus-Strong audio output stage.
package ks_audio_out_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_RAMP_STEP  = 1;

    typedef enum logic [1:0] {
        ST_MUTED = 2'd0,
        ST_RAMP  = 2'd1,
        ST_PLAY  = 2'd2
    } state_e;

    typedef enum logic {
        MODE_PWM = 1'b0,
        MODE_SD  = 1'b1
    } mode_e;

endpackage

// File: rtl/ks_audio_out_if.sv
// Sample handshake between the string voice (master) and the output stage (slave).
interface ks_audio_out_if
    import ks_audio_out_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic signed [DATA_WIDTH-1:0] sample;
    logic                         sample_valid;
    logic                         frame;

    modport master (output sample, output sample_valid, input frame);
    modport slave  (input sample, input sample_valid, output frame);

endinterface

// File: rtl/ks_pwm_sd_mod.sv
// 1-bit modulator: PWM compare against the frame counter or first-order sigma-delta.
module ks_pwm_sd_mod
    import ks_audio_out_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] cnt,
    input  logic [DATA_WIDTH-1:0] duty,
    input  mode_e                 mode,
    input  logic                  clr,
    output logic                  audio
);

    localparam int W = DATA_WIDTH;

    logic [W:0] acc;

    // The carry out of the accumulator is the sigma-delta bitstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            audio <= 1'b0;
        end else begin
            if (clr) begin
                acc <= '0;
            end else begin
                acc <= {1'b0, acc[W-1:0]} + {1'b0, duty};
            end
            audio <= (mode == MODE_SD) ? acc[W] : (cnt < duty);
        end
    end

endmodule

// File: rtl/ks_audio_out.sv
// Output stage for the string voice: frame pacing, one-deep sample buffer,
// volume shift, click-free mute ramp and 1-bit PWM / sigma-delta output.
module ks_audio_out
    import ks_audio_out_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RAMP_STEP  = DEF_RAMP_STEP
) (
    input  logic           clk_i,
    input  logic           rst_n,
    ks_audio_out_if.slave  voice,
    input  logic [2:0]     volume_i,
    input  logic           mute_i,
    input  logic           mode_i,
    input  logic           overrun_clr_i,
    output logic           audio_o,
    output logic           frame_o,
    output logic           muted_o,
    output logic           overrun_o,
    output logic           underrun_o
);

    localparam int W = DATA_WIDTH;
    typedef logic signed [W:0] wide_t;
    localparam wide_t                STEP_W = wide_t'(RAMP_STEP);
    localparam logic signed [W-1:0]  STEP_N = W'(RAMP_STEP);

    logic [W-1:0]        cnt;
    logic                frame;
    logic signed [W-1:0] pend;
    logic                pend_full;
    logic signed [W-1:0] target;
    logic signed [W-1:0] next_target;
    logic signed [W-1:0] level;
    logic signed [W-1:0] level_nxt;
    logic signed [W-1:0] goal;
    logic                overrun_set;
    logic                underrun_set;
    logic                clr_acc;
    logic [W-1:0]        duty;
    state_e              state;
    mode_e               mode_q;

    function automatic logic signed [W-1:0] attenuate(input logic signed [W-1:0] s,
                                                      input logic [2:0] sh);
        return s >>> sh;
    endfunction

    // Difference taken one bit wider so a full-scale swing cannot wrap.
    function automatic logic signed [W-1:0] ramp_toward(input logic signed [W-1:0] cur,
                                                        input logic signed [W-1:0] dst);
        wide_t diff;
        diff = wide_t'(dst) - wide_t'(cur);
        if (diff > STEP_W) begin
            return cur + STEP_N;
        end else if (diff < -STEP_W) begin
            return cur - STEP_N;
        end
        return dst;
    endfunction

    assign frame       = &cnt;
    assign frame_o     = frame;
    assign voice.frame = frame;

    always_comb begin
        next_target = target;
        if (frame && voice.sample_valid) begin
            next_target = attenuate(voice.sample, volume_i);
        end else if (frame && pend_full) begin
            next_target = attenuate(pend, volume_i);
        end
    end

    assign goal         = mute_i ? '0 : next_target;
    assign level_nxt    = ramp_toward(level, goal);
    assign overrun_set  = voice.sample_valid && pend_full && !frame;
    assign underrun_set = frame && !voice.sample_valid && !pend_full && (state == ST_PLAY);
    assign clr_acc      = frame && (mode_e'(mode_i) != mode_q);
    assign duty         = {~level[W-1], level[W-2:0]};

    // Buffer data only; its validity lives in pend_full.
    always_ff @(posedge clk_i) begin
        if (voice.sample_valid && !frame) begin
            pend <= voice.sample;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            target     <= '0;
            level      <= '0;
            pend_full  <= 1'b0;
            mode_q     <= MODE_PWM;
            overrun_o  <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            cnt <= cnt + W'(1);
            if (frame) begin
                target    <= next_target;
                level     <= level_nxt;
                mode_q    <= mode_e'(mode_i);
                pend_full <= 1'b0;
            end else if (voice.sample_valid) begin
                pend_full <= 1'b1;
            end
            overrun_o  <= overrun_set  | (overrun_o  & ~overrun_clr_i);
            underrun_o <= underrun_set | (underrun_o & ~overrun_clr_i);
        end
    end

    // Mute/ramp FSM; decisions use the level that results from this frame's step.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_MUTED;
            muted_o <= 1'b1;
        end else if (frame) begin
            case (state)
                ST_MUTED: begin
                    if (!mute_i) begin
                        state   <= ST_RAMP;
                        muted_o <= 1'b0;
                    end
                end
                ST_RAMP: begin
                    if (!mute_i && (level_nxt == goal)) begin
                        state <= ST_PLAY;
                    end else if (mute_i && (level_nxt == '0)) begin
                        state   <= ST_MUTED;
                        muted_o <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (mute_i || (level_nxt != goal)) begin
                        state <= ST_RAMP;
                    end
                end
                default: begin
                    state   <= ST_MUTED;
                    muted_o <= 1'b1;
                end
            endcase
        end
    end

    ks_pwm_sd_mod #(
        .DATA_WIDTH (W)
    ) u_mod (
        .clk   (clk_i),
        .rst_n (rst_n),
        .cnt   (cnt),
        .duty  (duty),
        .mode  (mode_q),
        .clr   (clr_acc),
        .audio (audio_o)
    );

endmodule

// File: tb/tb_ks_audio_out.sv
// Frame-level bench for ks_audio_out: directed table plus randomized frames against a reference model.
module tb_ks_audio_out;

    localparam int W    = 8;
    localparam int STEP = 1;
    localparam int MS_MUTED = 0;
    localparam int MS_RAMP  = 1;
    localparam int MS_PLAY  = 2;

    typedef struct {
        bit mute;
        bit mode;
        int vol;
        int p0;
        int s0;
        int p1;
        int s1;
        bit clr;
    } stim_t;

    typedef struct {
        stim_t st;
        int    ex_cnt;
        int    ex_muted;
        int    ex_ovr;
        int    ex_unr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] volume = '0;
    logic       mute = 1'b1;
    logic       mode = 1'b0;
    logic       overrun_clr = 1'b0;
    logic       audio, frame, muted, overrun, underrun;

    int n_vec = 0;
    int n_bad = 0;

    int m_level, m_target, m_pend, m_state;
    bit m_pend_full, m_ovr, m_unr;
    int m_mode_cur, m_mode_prev, m_duty_cur, m_duty_prev;
    bit cur_mute, cur_mode;

    ks_audio_out_if #(.DATA_WIDTH(W)) voice_if ();

    ks_audio_out #(
        .DATA_WIDTH (W),
        .RAMP_STEP  (STEP)
    ) dut (
        .clk_i         (clk),
        .rst_n         (rst_n),
        .voice         (voice_if),
        .volume_i      (volume),
        .mute_i        (mute),
        .mode_i        (mode),
        .overrun_clr_i (overrun_clr),
        .audio_o       (audio),
        .frame_o       (frame),
        .muted_o       (muted),
        .overrun_o     (overrun),
        .underrun_o    (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    function automatic stim_t mk(bit mu, bit mo, int vol, int p0, int s0, int p1, int s1, bit clr);
        stim_t s;
        s.mute = mu; s.mode = mo; s.vol = vol;
        s.p0 = p0; s.s0 = s0; s.p1 = p1; s.s1 = s1; s.clr = clr;
        return s;
    endfunction

    task automatic model_reset();
        m_level = 0; m_target = 0; m_pend = 0; m_pend_full = 0;
        m_state = MS_MUTED; m_ovr = 0; m_unr = 0;
        m_mode_cur = 0; m_mode_prev = 0; m_duty_cur = 128; m_duty_prev = 128;
    endtask

    task automatic model_take(input int p, input int s, inout bit v255, inout int s255);
        if (p == 255) begin
            v255 = 1; s255 = s;
        end else if (p >= 0) begin
            if (m_pend_full) m_ovr = 1;
            m_pend = s;
            m_pend_full = 1;
        end
    endtask

    // One whole frame of events, then the end-of-frame transfer, ramp and state decision.
    task automatic model_frame(input stim_t st);
        int goal, d, nl, s255;
        bit v255;
        if (st.clr) begin m_ovr = 0; m_unr = 0; end
        v255 = 0; s255 = 0;
        model_take(st.p0, st.s0, v255, s255);
        model_take(st.p1, st.s1, v255, s255);
        if (v255) begin
            m_target = s255 >>> st.vol; m_pend_full = 0;
        end else if (m_pend_full) begin
            m_target = m_pend >>> st.vol; m_pend_full = 0;
        end else if (m_state == MS_PLAY) begin
            m_unr = 1;
        end
        goal = st.mute ? 0 : m_target;
        d = goal - m_level;
        nl = (d > STEP) ? m_level + STEP : (d < -STEP) ? m_level - STEP : goal;
        case (m_state)
            MS_MUTED: if (!st.mute) m_state = MS_RAMP;
            MS_RAMP: begin
                if (!st.mute && nl == goal) m_state = MS_PLAY;
                else if (st.mute && nl == 0) m_state = MS_MUTED;
            end
            default: if (st.mute || nl != goal) m_state = MS_RAMP;
        endcase
        m_level = nl;
        m_duty_prev = m_duty_cur; m_duty_cur = m_level + 128;
        m_mode_prev = m_mode_cur; m_mode_cur = st.mode;
    endtask

    // Entered on the falling edge of the cnt==0 cycle; leaves on the next one.
    task automatic do_frame(input stim_t st, input int ex_cnt, input int ex_muted,
                            input int ex_ovr, input int ex_unr, input bit use_model);
        int e_cnt, e_m, e_o, e_u, highs, fbad;
        if (use_model) begin
            e_m = (m_state == MS_MUTED); e_o = m_ovr; e_u = m_unr; e_cnt = -1;
            if (m_mode_prev == m_mode_cur && (m_mode_cur == 0 || m_duty_prev == m_duty_cur))
                e_cnt = m_duty_cur;
        end else begin
            e_m = ex_muted; e_o = ex_ovr; e_u = ex_unr; e_cnt = ex_cnt;
        end
        check("muted_o", muted, e_m);
        check("overrun_o", overrun, e_o);
        check("underrun_o", underrun, e_u);
        mute = st.mute; mode = st.mode; volume = 3'(st.vol);
        highs = 0; fbad = 0;
        for (int c = 0; c < 256; c++) begin
            if ((frame !== (c == 255)) || (voice_if.frame !== frame)) fbad++;
            if (audio === 1'b1) highs++;
            voice_if.sample_valid = (c == st.p0) || (c == st.p1);
            voice_if.sample = (c == st.p0) ? 8'(st.s0) : (c == st.p1) ? 8'(st.s1) : 8'h00;
            overrun_clr = (c == 0) && st.clr;
            @(negedge clk);
        end
        voice_if.sample_valid = 1'b0;
        overrun_clr = 1'b0;
        if (e_cnt >= 0) check("audio_high_count", highs, e_cnt);
        check("frame_o_position", fbad, 0);
        model_frame(st);
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        int r, v;
        if ($urandom_range(0, 9) == 0) cur_mute = !cur_mute;
        if ($urandom_range(0, 9) == 0) cur_mode = !cur_mode;
        s.mute = cur_mute; s.mode = cur_mode;
        s.vol = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0;
        s.clr = ($urandom_range(0, 4) == 0);
        s.p0 = -1; s.p1 = -1; s.s0 = 0; s.s1 = 0;
        r = int'($urandom_range(0, 9));
        if (r >= 8) begin
            s.p0 = int'($urandom_range(1, 200));
            s.p1 = int'($urandom_range(s.p0 + 1, 255));
        end else if (r >= 1) begin
            s.p0 = int'($urandom_range(1, 255));
        end
        for (int k = 0; k < 2; k++) begin
            if ($urandom_range(0, 9) < 7) v = m_level + int'($urandom_range(0, 2)) - 1;
            else v = int'($urandom_range(0, 255)) - 128;
            if (v > 127) v = 127;
            if (v < -128) v = -128;
            if (k == 0) s.s0 = v; else s.s1 = v;
        end
        return s;
    endfunction

    initial begin
        vec_t tbl[17];
        voice_if.sample = '0;
        voice_if.sample_valid = 1'b0;
        tbl[0]  = '{mk(0,0,0, 30, 16,  -1,  0,0), 144, 0, 0, 0};
        tbl[1]  = '{mk(0,0,0, 20,'h20, 40,'h30,0), 144, 0, 0, 0};
        tbl[2]  = '{mk(0,0,0, 10, 16,  -1,  0,1), 145, 0, 1, 0};
        tbl[3]  = '{mk(0,0,2,100, 16, 255,'h44,0), 144, 0, 0, 0};
        tbl[4]  = '{mk(0,0,0, -1,  0,  -1,  0,0), 145, 0, 0, 0};
        tbl[5]  = '{mk(0,0,0, -1,  0,  -1,  0,0), 145, 0, 0, 1};
        tbl[6]  = '{mk(0,0,0,  5, 17,  -1,  0,1), 145, 0, 0, 1};
        tbl[7]  = '{mk(0,0,0,  5, 17,  -1,  0,0), 145, 0, 0, 0};
        tbl[8]  = '{mk(0,1,0,  5, 17,  -1,  0,0), 145, 0, 0, 0};
        tbl[9]  = '{mk(0,1,0,  5, 17,  -1,  0,0),  -1, 0, 0, 0};
        tbl[10] = '{mk(0,1,0,  5, 17,  -1,  0,0), 145, 0, 0, 0};
        tbl[11] = '{mk(0,1,0,  5, 17,  -1,  0,0), 145, 0, 0, 0};
        tbl[12] = '{mk(0,0,0,  5, 17,  -1,  0,0), 145, 0, 0, 0};
        tbl[13] = '{mk(0,0,0,  5, 17,  -1,  0,0),  -1, 0, 0, 0};
        tbl[14] = '{mk(0,0,0,  5, 17,  -1,  0,0), 145, 0, 0, 0};
        tbl[15] = '{mk(0,0,2,  5,-64,  -1,  0,0), 145, 0, 0, 0};
        tbl[16] = '{mk(0,0,2,  5,-64,  -1,  0,0), 144, 0, 0, 0};

        model_reset();
        @(negedge clk);
        check("reset_audio_o", audio, 0);
        check("reset_frame_o", frame, 0);
        check("reset_muted_o", muted, 1);
        check("reset_overrun_o", overrun, 0);
        check("reset_underrun_o", underrun, 0);
        rst_n = 1'b1;

        // Muted idle: midscale duty.
        for (int f = 0; f < 2; f++)
            do_frame(mk(1,0,0,-1,0,-1,0,0), 128, 1, 0, 0, 0);

        // Unmute with a constant 0x10 stream: level climbs one LSB per frame.
        for (int k = 0; k <= 16; k++)
            do_frame(mk(0,0,0,10,'h10,-1,0,0), 128 + k, (k == 0), 0, 0, 0);

        for (int i = 0; i < 17; i++)
            do_frame(tbl[i].st, tbl[i].ex_cnt, tbl[i].ex_muted, tbl[i].ex_ovr, tbl[i].ex_unr, 0);

        cur_mute = 0; cur_mode = 0;
        for (int f = 0; f < 100; f++)
            do_frame(rand_stim(), 0, 0, 0, 0, 1);

        // Mid-frame asynchronous reset after forcing an overrun.
        mute = 1'b0;
        for (int c = 0; c < 100; c++) begin
            voice_if.sample_valid = (c == 10) || (c == 20);
            voice_if.sample = 8'h05;
            @(negedge clk);
        end
        voice_if.sample_valid = 1'b0;
        check("overrun_before_reset", overrun, 1);
        rst_n = 1'b0;
        #1;
        check("midreset_audio_o", audio, 0);
        check("midreset_frame_o", frame, 0);
        check("midreset_muted_o", muted, 1);
        check("midreset_overrun_o", overrun, 0);
        check("midreset_underrun_o", underrun, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_frame(mk(1,0,0,-1,0,-1,0,0), 0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
